sm_intc: RTL

SM_INTC -- requirements
Module: sm_intc

---
 rtl/sm_intc.sv | 106 ++++++++++
 1 files changed

// File: rtl/sm_intc.sv
// Six-source interrupt controller: five external lines plus the CP0 timer, with
// per-line mask, edge/level mode and polarity. Define SM_CONFIG_INTC_SYNC_EN for a 2-flop input synchronizer.
module sm_intc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ext_irq,
  input  logic        cp0_TI,
  output logic [5:0]  cp0_ExcIP,
  input  logic [3:0]  intc_Addr,
  input  logic        intc_WE,
  input  logic [31:0] intc_WD,
  output logic [31:0] intc_RD
);

  typedef enum logic [1:0] {
    REG_PEND = 2'd0,
    REG_MASK = 2'd1,
    REG_MODE = 2'd2,
    REG_POL  = 2'd3
  } regSel_e;

  regSel_e    sel;
  logic [5:0] pend, pendNext, mask;
  logic [4:0] mode, pol, active, prevActive;
  logic [4:0] syncQ;
  logic       wrPend, wrMask, wrMode, wrPol;
  logic       unusedBits;

  assign sel        = regSel_e'(intc_Addr[3:2]);
  assign unusedBits = ^{intc_Addr[1:0], intc_WD[31:6]};

`ifdef SM_CONFIG_INTC_SYNC_EN
  logic [4:0] syncMeta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncMeta <= '0;
      syncQ    <= '0;
    end else begin
      syncMeta <= ext_irq;
      syncQ    <= syncMeta;
    end
  end
`else
  // Single capture register: ext_irq is assumed synchronous to clk in this build.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) syncQ <= '0;
    else        syncQ <= ext_irq;
  end
`endif

  assign active = syncQ ^ pol;
  assign wrPend = intc_WE && (sel == REG_PEND);
  assign wrMask = intc_WE && (sel == REG_MASK);
  assign wrMode = intc_WE && (sel == REG_MODE);
  assign wrPol  = intc_WE && (sel == REG_POL);

  // Priority per bit: mode change clears, then a fresh edge sets, then a PEND write clears.
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    pendNext = pend;
    for (int i = 0; i < 5; i++) begin
      if (wrMode && (intc_WD[i] != mode[i])) begin
        pendNext[i] = 1'b0;
      end else if (mode[i]) begin
        if (active[i] && !prevActive[i]) pendNext[i] = 1'b1;
        else if (wrPend && intc_WD[i])   pendNext[i] = 1'b0;
      end else begin
        pendNext[i] = active[i];
      end
    end
    pendNext[5] = cp0_TI;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= '0;
      mask       <= '0;
      mode       <= '0;
      pol        <= '0;
      prevActive <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      pend       <= pendNext;
      // Re-base the edge history on the new polarity so a POL write is not seen as an edge.
      prevActive <= wrPol ? (syncQ ^ intc_WD[4:0]) : active;
      if (wrMask) mask <= intc_WD[5:0];
      if (wrMode) mode <= intc_WD[4:0];
      if (wrPol)  pol  <= intc_WD[4:0];
    end
  end

  assign cp0_ExcIP = pend & mask;

  always_comb begin
    intc_RD = '0;
    case (sel)
      REG_PEND: intc_RD[5:0] = pend;
      REG_MASK: intc_RD[5:0] = mask;
      REG_MODE: intc_RD[4:0] = mode;
      REG_POL:  intc_RD[4:0] = pol;
      default:  intc_RD = '0;
    endcase
  end

endmodule
